sync_io_pipe: RTL



---
 rtl/sync_io_pipe.sv | 116 +++++++++++
 1 files changed

// File: rtl/sync_io_pipe.sv
// sync_io_pipe: DEPTH-stage input-capture pipeline with hold, output-stability detector,
// valid-word counter and forwarded clocks. Define SYNC_IO_PARITY_EN to carry and check even parity.
module sync_io_pipe #(
    parameter int DW       = 4,
    parameter int DEPTH    = 2,
    parameter int NCLK     = 2,
    parameter int STABLE_N = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [DW-1:0]   Din,
    input  logic            Din_valid,
`ifdef SYNC_IO_PARITY_EN
    input  logic            Din_par,
`endif
    input  logic            Hold,
    output logic [DW-1:0]   Dout,
    output logic            Dout_valid,
    output logic            Dout_stable,
    output logic [15:0]     Word_cnt,
`ifdef SYNC_IO_PARITY_EN
    output logic            Par_err,
`endif
    output logic [NCLK-1:0] ext_clk
);

    localparam int             SW   = $clog2(STABLE_N + 1);
    localparam logic [SW-1:0]  SMAX = SW'(STABLE_N);

    logic [DW-1:0] stage_data [DEPTH];
    logic          stage_vld  [DEPTH];
    logic [DW-1:0] in_data    [DEPTH];
    logic          in_vld     [DEPTH];
    logic [SW-1:0] scnt;
    logic [15:0]   word_cnt;
    logic [DW-1:0] new_data;
    logic          new_vld;

`ifdef SYNC_IO_PARITY_EN
    logic stage_par [DEPTH];
    logic in_par    [DEPTH];
    logic new_par;
    logic par_err;
`endif

    // Input of every stage: stage 0 takes the pins, the rest take their predecessor.
    // NOTE: every element is written on every pass through this block, so no latch is inferred.
    always_comb begin
        in_data[0] = Din;
        in_vld[0]  = Din_valid;
`ifdef SYNC_IO_PARITY_EN
        in_par[0]  = Din_par;
`endif
        for (int k = 1; k < DEPTH; k++) begin
            in_data[k] = stage_data[k-1];
            in_vld[k]  = stage_vld[k-1];
`ifdef SYNC_IO_PARITY_EN
            in_par[k]  = stage_par[k-1];
`endif
        end
    end

    // What the last stage will hold after the next non-Hold edge.
    assign new_data = in_data[DEPTH-1];
    assign new_vld  = in_vld[DEPTH-1];
`ifdef SYNC_IO_PARITY_EN
    assign new_par  = in_par[DEPTH-1];
`endif

    // NOTE: state is updated with non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: the stage chain is plain flops, reset explicitly so reset flushes in-flight words.
            for (int k = 0; k < DEPTH; k++) begin
                stage_data[k] <= '0;
                stage_vld[k]  <= 1'b0;
`ifdef SYNC_IO_PARITY_EN
                stage_par[k]  <= 1'b0;
`endif
            end
            scnt     <= '0;
            word_cnt <= '0;
`ifdef SYNC_IO_PARITY_EN
            par_err  <= 1'b0;
`endif
        end else if (!Hold) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_data[k] <= in_data[k];
                stage_vld[k]  <= in_vld[k];
`ifdef SYNC_IO_PARITY_EN
                stage_par[k]  <= in_par[k];
`endif
            end
            if (!new_vld || !stage_vld[DEPTH-1] || (new_data != stage_data[DEPTH-1]))
                scnt <= '0;
            else if (scnt != SMAX)
                scnt <= scnt + 1'b1;
            if (new_vld)
                word_cnt <= word_cnt + 16'd1;
`ifdef SYNC_IO_PARITY_EN
            if (new_vld && ((^new_data) != new_par))
                par_err <= 1'b1;
`endif
        end
    end

    assign Dout        = stage_data[DEPTH-1];
    assign Dout_valid  = stage_vld[DEPTH-1];
    assign Dout_stable = (scnt == SMAX);
    assign Word_cnt    = word_cnt;
`ifdef SYNC_IO_PARITY_EN
    assign Par_err     = par_err;
`endif
    assign ext_clk     = {NCLK{CLK}};

endmodule
